// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen timing, colour constants and the packed pixel bus
// carried between draw stages.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COLOR_BLACK = 12'h000;
    localparam rgb_t COLOR_WHITE = 12'hFFF;
    localparam rgb_t COLOR_KEY   = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        rgb_t        rgb;
    } vga_bus_t;

    // Half-open interval test [lo, lo+span); 13 bits so lo+span cannot wrap.
    function automatic logic in_span(
        input logic [12:0] v,
        input logic [12:0] lo,
        input logic [12:0] span
    );
        return (v >= lo) && (v < (lo + span));
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle passed between draw stages; a stage reads through `in`
// and drives through `out`.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// Fixed-length delay line for the VGA pixel bus (timing fields plus rgb), used to
// keep the stream aligned with a draw stage's processing latency.
module vga_delay
    import vga_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  vga_bus_t din,
    output vga_bus_t dout
);

    vga_bus_t pipe_r [STAGES];

    // shift register, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[STAGES-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: three-stage pipeline that keys a ROM sprite over the stream
// at a position latched each vblank. Optional horizontal flip: SPRITE_MIRROR_EN.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int         WIDTH     = 48,
    parameter int         HEIGHT    = 48,
    parameter logic [11:0] KEY_COLOR = COLOR_KEY,
    parameter int         ADDR_W    = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_if.in                 in,
    vga_if.out                out,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data
`ifdef SPRITE_MIRROR_EN
    ,
    input  logic              mirror
`endif
);

    localparam logic [12:0] SPR_W = 13'(WIDTH);
    localparam logic [12:0] SPR_H = 13'(HEIGHT);

    logic              vblnk_d_r;
    logic [11:0]       x_lat_r;
    logic [11:0]       y_lat_r;
`ifdef SPRITE_MIRROR_EN
    logic              mirror_lat_r;
`endif

    logic              hit_s;
    logic              hit_s1_r;
    logic              hit_s2_r;
    logic [12:0]       h_s;
    logic [12:0]       v_s;
    logic [12:0]       col_s;
    logic [12:0]       row_s;
    logic [12:0]       col_sel_s;
    logic [ADDR_W-1:0] addr_s;
    logic [11:0]       out_rgb_s;

    vga_bus_t          in_bus_s;
    vga_bus_t          dly_bus_s;
    vga_bus_t          out_bus_r;

    // frame position latch: loads only on the rising edge of vblnk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d_r    <= 1'b0;
            x_lat_r      <= 12'd0;
            y_lat_r      <= 12'd0;
`ifdef SPRITE_MIRROR_EN
            mirror_lat_r <= 1'b0;
`endif
        end else begin
            vblnk_d_r <= in.vblnk;
            if (in.vblnk && !vblnk_d_r) begin
                x_lat_r      <= xpos;
                y_lat_r      <= ypos;
`ifdef SPRITE_MIRROR_EN
                mirror_lat_r <= mirror;
`endif
            end
        end
    end

    // hit test and row-major sprite address for the incoming pixel
    always_comb begin
        h_s   = {2'b00, in.hcount};
        v_s   = {2'b00, in.vcount};
        hit_s = !in.hblnk && !in.vblnk
                && in_span(h_s, {1'b0, x_lat_r}, SPR_W)
                && in_span(v_s, {1'b0, y_lat_r}, SPR_H);
        col_s = h_s - {1'b0, x_lat_r};
        row_s = v_s - {1'b0, y_lat_r};
`ifdef SPRITE_MIRROR_EN
        if (mirror_lat_r) begin
            col_sel_s = SPR_W - 13'd1 - col_s;
        end else begin
            col_sel_s = col_s;
        end
`else
        col_sel_s = col_s;
`endif
        // outside the sprite the address parks at 0 so the ROM sees no stray reads
        if (hit_s) begin
            addr_s = ADDR_W'(32'(row_s) * 32'(WIDTH) + 32'(col_sel_s));
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    assign in_bus_s = '{
        hcount: in.hcount,
        vcount: in.vcount,
        hsync:  in.hsync,
        vsync:  in.vsync,
        hblnk:  in.hblnk,
        vblnk:  in.vblnk,
        rgb:    in.rgb
    };

    vga_delay #(
        .STAGES (2)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_bus_s),
        .dout  (dly_bus_s)
    );

    // s1 issues the ROM address; hit travels alongside the ROM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= {ADDR_W{1'b0}};
            hit_s1_r <= 1'b0;
            hit_s2_r <= 1'b0;
        end else begin
            rom_addr <= addr_s;
            hit_s1_r <= hit_s;
            hit_s2_r <= hit_s1_r;
        end
    end

    // colour-key mux between sprite pixel and delayed background
    always_comb begin
        if (hit_s2_r && (rom_data != KEY_COLOR)) begin
            out_rgb_s = rom_data;
        end else begin
            out_rgb_s = dly_bus_s.rgb;
        end
    end

    // output stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bus_r <= '0;
        end else begin
            out_bus_r     <= dly_bus_s;
            out_bus_r.rgb <= out_rgb_s;
        end
    end

    assign out.hcount = out_bus_r.hcount;
    assign out.vcount = out_bus_r.vcount;
    assign out.hsync  = out_bus_r.hsync;
    assign out.vsync  = out_bus_r.vsync;
    assign out.hblnk  = out_bus_r.hblnk;
    assign out.vblnk  = out_bus_r.vblnk;
    assign out.rgb    = out_bus_r.rgb;

endmodule
